// File: rtl/mips_lsu_burst.sv
// ============================================================================
// mips_lsu_burst
//   Multi-word load/store sequencer between the register file and data SRAM.
//   Optional macro MIPS_LSU_ALIGN_CHECK_EN rejects unaligned or mis-paired bursts.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module mips_lsu_burst #(
    parameter int MAX_WORDS = 4,
    parameter int CNT_W     = 3,
    parameter int ADDR_W    = 7,
    parameter int READ_LAT  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [31:0]       req_addr,
    input  logic [CNT_W-1:0]  req_count,
    input  logic [4:0]        req_reg,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [4:0]        reg_rd_idx,
    input  logic [31:0]       reg_rd_data,
    output logic              reg_wr_en,
    output logic [4:0]        reg_wr_idx,
    output logic [31:0]       reg_wr_data,
    output logic              CEN,
    output logic              WEN,
    output logic              OEN,
    output logic [ADDR_W-1:0] A,
    output logic [31:0]       Data2Mem,
    input  logic [31:0]       ReadDataMem
);

    localparam logic [CNT_W-1:0] c_max_cnt = CNT_W'(MAX_WORDS);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DRAIN  = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_idx;
    logic [4:0]        r_reg;
    logic              r_store;
    logic              r_err;

    logic              w_bad;
    logic              w_last;
    logic              w_access;
    logic [ADDR_W-1:0] w_addr;
    logic [4:0]        w_reg_idx;
    logic              w_unused;

    assign w_access  = (r_state == S_ACCESS);
    assign w_last    = (r_idx == r_cnt - 1'b1);
    assign w_addr    = r_base + ADDR_W'(r_idx);
    assign w_reg_idx = r_reg + 5'(r_idx);

`ifdef MIPS_LSU_ALIGN_CHECK_EN
    assign w_unused = &{1'b0, req_addr[31:ADDR_W+2]};
    // An even-length burst from an odd register would split an FP pair.
    assign w_bad = (req_count == '0) || (req_count > c_max_cnt)
                || (req_addr[1:0] != 2'b00)
                || (req_reg[0] && !req_count[0]);
`else
    assign w_unused = &{1'b0, req_addr[31:ADDR_W+2], req_addr[1:0]};
    assign w_bad = (req_count == '0) || (req_count > c_max_cnt);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_base  <= '0;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_reg   <= '0;
            r_store <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == S_IDLE && req_valid) begin
            r_base  <= req_addr[ADDR_W+1:2];
            r_cnt   <= req_count;
            r_idx   <= '0;
            r_reg   <= req_reg;
            r_store <= req_store;
            r_err   <= w_bad;
        end else if (w_access) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    always_comb begin
        w_next   = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_next = w_bad ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (w_last) begin
                    w_next = (!r_store && READ_LAT == 1) ? S_DRAIN : S_DONE;
                end
            end
            S_DRAIN: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == S_IDLE);
        stall      = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        err        = (r_state == S_DONE) && r_err;
        CEN        = !w_access;
        WEN        = !(w_access && r_store);
        OEN        = !(w_access && !r_store);
        A          = w_access ? w_addr : '0;
        Data2Mem   = (w_access && r_store) ? reg_rd_data : 32'd0;
        reg_rd_idx = w_reg_idx;
    end

    generate
        if (READ_LAT == 0) begin : g_lat0
            assign reg_wr_en   = w_access && !r_store;
            assign reg_wr_idx  = w_reg_idx;
            assign reg_wr_data = ReadDataMem;
        end else begin : g_lat1
            // Writeback trails the SRAM issue by one cycle; the last one lands in DRAIN.
            logic       r_wb_en;
            logic [4:0] r_wb_idx;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_wb_en  <= 1'b0;
                    r_wb_idx <= '0;
                end else begin
                    r_wb_en  <= w_access && !r_store;
                    r_wb_idx <= w_reg_idx;
                end
            end

            assign reg_wr_en   = r_wb_en;
            assign reg_wr_idx  = r_wb_idx;
            assign reg_wr_data = ReadDataMem;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_mips_lsu_burst.sv
// ============================================================================
// tb_mips_lsu_burst
//   Scoreboard bench: stimulus queues expected SRAM/regfile/done events,
//   a negedge monitor pops and compares them as the DUT produces them.
//   Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mips_lsu_burst;

    localparam int ADDR_W = 7;
    localparam int CNT_W  = 3;
    localparam int LAT    = 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic              req_store = 1'b0;
    logic [31:0]       req_addr = '0;
    logic [CNT_W-1:0]  req_count = '0;
    logic [4:0]        req_reg = '0;
    logic              stall;
    logic              done;
    logic              err;
    logic [4:0]        reg_rd_idx;
    logic [31:0]       reg_rd_data;
    logic              reg_wr_en;
    logic [4:0]        reg_wr_idx;
    logic [31:0]       reg_wr_data;
    logic              CEN;
    logic              WEN;
    logic              OEN;
    logic [ADDR_W-1:0] A;
    logic [31:0]       Data2Mem;
    logic [31:0]       ReadDataMem;

    mips_lsu_burst #(
        .MAX_WORDS(4),
        .CNT_W    (CNT_W),
        .ADDR_W   (ADDR_W),
        .READ_LAT (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_addr   (req_addr),
        .req_count  (req_count),
        .req_reg    (req_reg),
        .stall      (stall),
        .done       (done),
        .err        (err),
        .reg_rd_idx (reg_rd_idx),
        .reg_rd_data(reg_rd_data),
        .reg_wr_en  (reg_wr_en),
        .reg_wr_idx (reg_wr_idx),
        .reg_wr_data(reg_wr_data),
        .CEN        (CEN),
        .WEN        (WEN),
        .OEN        (OEN),
        .A          (A),
        .Data2Mem   (Data2Mem),
        .ReadDataMem(ReadDataMem)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file and SRAM models
    logic [31:0] rf  [32];
    logic [31:0] mem [128];
    logic [31:0] rd_q = '0;

    assign reg_rd_data = rf[reg_rd_idx];
    assign ReadDataMem = (LAT == 0) ? mem[A] : rd_q;

    always @(posedge clk) begin
        if (CEN === 1'b0 && WEN === 1'b0) mem[A] <= Data2Mem;
        if (CEN === 1'b0 && OEN === 1'b0) rd_q <= mem[A];
        if (reg_wr_en === 1'b1) rf[reg_wr_idx] <= reg_wr_data;
    end

    typedef struct {
        int                cyc;
        logic [ADDR_W-1:0] a;
        logic              we;
        logic [31:0]       d;
    } mem_exp_t;

    typedef struct {
        int          cyc;
        logic [4:0]  idx;
        logic [31:0] d;
    } wr_exp_t;

    typedef struct {
        int   cyc;
        logic e;
    } done_exp_t;

    mem_exp_t  exp_mem  [$];
    wr_exp_t   exp_wr   [$];
    done_exp_t exp_done [$];
    mem_exp_t  m_e;
    wr_exp_t   w_e;
    done_exp_t d_e;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_mem(input int c, input int a, input logic we, input logic [31:0] d);
        mem_exp_t e;
        e.cyc = c; e.a = ADDR_W'(a); e.we = we; e.d = d;
        exp_mem.push_back(e);
    endtask

    task automatic push_wr(input int c, input int idx, input logic [31:0] d);
        wr_exp_t e;
        e.cyc = c; e.idx = 5'(idx); e.d = d;
        exp_wr.push_back(e);
    endtask

    task automatic push_done(input int c, input logic e_bit);
        done_exp_t e;
        e.cyc = c; e.e = e_bit;
        exp_done.push_back(e);
    endtask

    // Called at a negedge with expectations already queued; holds req_valid one cycle.
    task automatic drive(input logic st, input logic [31:0] addr, input int cnt, input int r);
        chk("req_ready_before", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_store = st;
        req_addr  = addr;
        req_count = CNT_W'(cnt);
        req_reg   = 5'(r);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
        chk("mem_queue_empty", exp_mem.size(), 32'd0);
        chk("wr_queue_empty", exp_wr.size(), 32'd0);
        chk("done_queue_empty", exp_done.size(), 32'd0);
        chk("req_ready_after", {31'd0, req_ready}, 32'd1);
        chk("stall_after", {31'd0, stall}, 32'd0);
    endtask

    always @(negedge clk) begin
        if (CEN === 1'b0) begin
            if (exp_mem.size() == 0) begin
                tests++; fails++;
                $display("FAIL mem_unexpected: got access A=%0d WEN=%b, required none (cycle %0d)", A, WEN, cyc);
            end else begin
                m_e = exp_mem.pop_front();
                chk("mem_cycle", cyc, m_e.cyc);
                chk("mem_A", {25'd0, A}, {25'd0, m_e.a});
                chk("mem_WEN", {31'd0, WEN}, {31'd0, m_e.we});
                chk("mem_OEN", {31'd0, OEN}, {31'd0, ~m_e.we});
                chk("mem_stall", {31'd0, stall}, 32'd1);
                if (m_e.we == 1'b0) chk("mem_data", Data2Mem, m_e.d);
            end
        end
        if (reg_wr_en === 1'b1) begin
            if (exp_wr.size() == 0) begin
                tests++; fails++;
                $display("FAIL wr_unexpected: got write R%0d=%h, required none (cycle %0d)", reg_wr_idx, reg_wr_data, cyc);
            end else begin
                w_e = exp_wr.pop_front();
                chk("wr_cycle", cyc, w_e.cyc);
                chk("wr_idx", {27'd0, reg_wr_idx}, {27'd0, w_e.idx});
                chk("wr_data", reg_wr_data, w_e.d);
            end
        end
        if (done === 1'b1) begin
            if (exp_done.size() == 0) begin
                tests++; fails++;
                $display("FAIL done_unexpected: got done err=%b, required none (cycle %0d)", err, cyc);
            end else begin
                d_e = exp_done.pop_front();
                chk("done_cycle", cyc, d_e.cyc);
                chk("done_err", {31'd0, err}, {31'd0, d_e.e});
                chk("done_stall", {31'd0, stall}, 32'd1);
            end
        end else if (err === 1'b1) begin
            tests++; fails++;
            $display("FAIL err_without_done: got err=1, required 0 (cycle %0d)", cyc);
        end
    end

    int t0;

    initial begin
        for (int k = 0; k < 128; k++) mem[k] = 32'hA000_0000 + k;
        for (int k = 0; k < 4; k++)   mem[8 + k] = 32'(k + 1);
        for (int k = 0; k < 32; k++)  rf[k] = 32'h5000_0000 + k;
        rf[4] = 32'hDEAD_BEEF;
        rf[5] = 32'h1234_5678;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_CEN", {31'd0, CEN}, 32'd1);
        chk("rst_WEN", {31'd0, WEN}, 32'd1);
        chk("rst_OEN", {31'd0, OEN}, 32'd1);
        chk("rst_A", {25'd0, A}, 32'd0);
        chk("rst_Data2Mem", Data2Mem, 32'd0);
        chk("rst_reg_wr_en", {31'd0, reg_wr_en}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        @(negedge clk);

        // Store 2 words from R4/R5 to words 4,5
        t0 = cyc;
        push_mem(t0 + 1, 4, 1'b0, 32'hDEAD_BEEF);
        push_mem(t0 + 2, 5, 1'b0, 32'h1234_5678);
        push_done(t0 + 3, 1'b0);
        drive(1'b1, 32'h10, 2, 4);
        settle(4);
        chk("mem4_written", mem[4], 32'hDEAD_BEEF);
        chk("mem5_written", mem[5], 32'h1234_5678);

        // Load 4 words 8..11 into R8..R11
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            push_mem(t0 + 1 + k, 8 + k, 1'b1, 32'd0);
            push_wr(t0 + 1 + LAT + k, 8 + k, 32'(k + 1));
        end
        push_done(t0 + 5 + LAT, 1'b0);
        drive(1'b0, 32'h20, 4, 8);
        settle(7);

        // Load 2 words crossing the address wrap: 127 then 0
        t0 = cyc;
        push_mem(t0 + 1, 127, 1'b1, 32'd0);
        push_mem(t0 + 2, 0,   1'b1, 32'd0);
        push_wr(t0 + 1 + LAT, 20, 32'hA000_007F);
        push_wr(t0 + 2 + LAT, 21, 32'hA000_0000);
        push_done(t0 + 3 + LAT, 1'b0);
        drive(1'b0, 32'h1FC, 2, 20);
        settle(5);

        // Illegal counts 0 and 5
        t0 = cyc;
        push_done(t0 + 1, 1'b1);
        drive(1'b0, 32'h20, 0, 8);
        settle(3);
        t0 = cyc;
        push_done(t0 + 1, 1'b1);
        drive(1'b1, 32'h20, 5, 8);
        settle(3);

        // Reset during the second word of a 4-word load
        t0 = cyc;
        push_mem(t0 + 1, 16, 1'b1, 32'd0);
        push_mem(t0 + 2, 17, 1'b1, 32'd0);
        if (LAT == 0) push_wr(t0 + 2, 13, 32'hA000_0011);
        push_wr(t0 + 1 + LAT, 12, 32'hA000_0010);
        drive(1'b0, 32'h40, 4, 12);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_CEN", {31'd0, CEN}, 32'd1);
        chk("midrst_OEN", {31'd0, OEN}, 32'd1);
        chk("midrst_wr_en", {31'd0, reg_wr_en}, 32'd0);
        t0 = cyc;
        push_mem(t0 + 1, 24, 1'b0, 32'hDEAD_BEEF);
        push_done(t0 + 2, 1'b0);
        drive(1'b1, 32'h60, 1, 4);
        settle(4);

`ifdef MIPS_LSU_ALIGN_CHECK_EN
        t0 = cyc;
        push_done(t0 + 1, 1'b1);
        drive(1'b0, 32'h12, 1, 2);
        settle(3);
        t0 = cyc;
        push_done(t0 + 1, 1'b1);
        drive(1'b0, 32'h30, 2, 3);
        settle(3);
`else
        // Unaligned address falls on word 4 (written by the first store)
        t0 = cyc;
        push_mem(t0 + 1, 4, 1'b1, 32'd0);
        push_wr(t0 + 1 + LAT, 2, 32'hDEAD_BEEF);
        push_done(t0 + 2 + LAT, 1'b0);
        drive(1'b0, 32'h12, 1, 2);
        settle(4);
        // Odd start register with even count is accepted
        t0 = cyc;
        push_mem(t0 + 1, 12, 1'b1, 32'd0);
        push_mem(t0 + 2, 13, 1'b1, 32'd0);
        push_wr(t0 + 1 + LAT, 3, 32'hA000_000C);
        push_wr(t0 + 2 + LAT, 4, 32'hA000_000D);
        push_done(t0 + 3 + LAT, 1'b0);
        drive(1'b0, 32'h30, 2, 3);
        settle(5);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
